// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI register bank.
package spi_pkg;
  localparam int N_DEF  = 8;
  localparam int CH_DEF = 4;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} spi_state_e;
endpackage

// File: rtl/spi_reg_bank_if.sv
// Serial session bus between an SPI-style master and the register bank.
interface spi_reg_bank_if;
  logic start;
  logic sel;
  logic si;
  logic so;

  modport master (output start, sel, si, input so);
  modport slave  (input start, sel, si, output so);
endinterface

// File: rtl/spi_shifter.sv
// N-bit load/shift register; outgoing bit leaves one end while si enters the other.
module spi_shifter #(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [N-1:0] i_load_val,
  input  logic         i_shift,
  input  logic         i_si,
  output logic [N-1:0] o_next,
  output logic         o_out
);
  logic [N-1:0] r_sh;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign o_next = {r_sh[N-2:0], i_si};
      assign o_out  = r_sh[N-1];
    end else begin : g_lsb
      assign o_next = {i_si, r_sh[N-1:1]};
      assign o_out  = r_sh[0];
    end
  endgenerate

  // load wins so a burst reload can coincide with the final shift
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_sh <= '0;
    else if (i_load)  r_sh <= i_load_val;
    else if (i_shift) r_sh <= o_next;
  end
endmodule

// File: rtl/spi_reg_bank.sv
// Serial-addressed register bank: address phase, then readback/write data phase.
// Burst auto-increment is enabled by defining SPI_REG_BANK_AUTOINC_EN.
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int CH        = CH_DEF,
  parameter int MSB_FIRST = 1,
  localparam int AW       = $clog2(CH)
) (
  input  logic            clk,
  input  logic            reset_n,
  spi_reg_bank_if.slave   bus,
  input  logic [CH*N-1:0] data_in,
  output logic [CH*N-1:0] q,
  output logic            wr_stb,
  output logic [AW-1:0]   wr_addr,
  output logic            full,
  output logic            addr_err
);
`ifdef SPI_REG_BANK_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int CW = $clog2((N > AW) ? N : AW);
  localparam logic [AW:0] CH_L = (AW+1)'(CH);

  spi_state_e            r_state;
  logic [CW-1:0]         r_cnt;
  logic [AW-1:0]         r_addr_sh, r_addr, r_wr_addr;
  logic [CH-1:0][N-1:0]  r_q;
  logic                  r_wr_stb, r_full, r_addr_err;

  logic [CH-1:0][N-1:0]  w_din;
  logic [AW-1:0]         w_addr_next, w_addr_inc, w_load_addr;
  logic [N-1:0]          w_word, w_load_val;
  logic                  w_act, w_last_abit, w_word_done, w_load, w_sh_out;
  logic                  w_next_ok, w_cur_ok, w_inc_ok, w_load_ok;

  assign w_din       = data_in;
  assign q           = r_q;
  assign wr_stb      = r_wr_stb;
  assign wr_addr     = r_wr_addr;
  assign full        = r_full;
  assign addr_err    = r_addr_err;

  assign w_addr_next = (MSB_FIRST != 0) ? AW'({r_addr_sh, bus.si})
                                        : AW'({bus.si, r_addr_sh} >> 1);
  assign w_addr_inc  = r_addr + AW'(1);
  assign w_next_ok   = {1'b0, w_addr_next} < CH_L;
  assign w_cur_ok    = {1'b0, r_addr}      < CH_L;
  assign w_inc_ok    = {1'b0, w_addr_inc}  < CH_L;

  assign w_act       = bus.sel && !bus.start;
  assign w_last_abit = w_act && (r_state == ADDR) && (r_cnt == CW'(AW-1));
  assign w_word_done = w_act && (r_state == DATA) && (r_cnt == CW'(N-1));
  assign w_load      = w_last_abit || (AUTOINC && w_word_done);
  assign w_load_addr = w_last_abit ? w_addr_next : w_addr_inc;
  assign w_load_ok   = w_last_abit ? w_next_ok : w_inc_ok;
  // out-of-range channels read back as zero
  assign w_load_val  = w_load_ok ? w_din[w_load_addr] : '0;

  spi_shifter #(.N(N), .MSB_FIRST(MSB_FIRST)) u_data_sh (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_shift    (w_act && (r_state == DATA)),
    .i_si       (bus.si),
    .o_next     (w_word),
    .o_out      (w_sh_out)
  );

  assign bus.so = (r_state == DATA) ? w_sh_out : 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr_sh  <= '0;
      r_addr     <= '0;
      r_q        <= '0;
      r_wr_stb   <= 1'b0;
      r_wr_addr  <= '0;
      r_full     <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_wr_stb <= 1'b0;
      if (bus.start) begin
        r_state    <= ADDR;
        r_cnt      <= '0;
        r_addr_sh  <= '0;
        r_full     <= 1'b0;
        r_addr_err <= 1'b0;
      end else if (bus.sel) begin
        case (r_state)
          ADDR: begin
            r_addr_sh <= w_addr_next;
            if (w_last_abit) begin
              r_addr     <= w_addr_next;
              r_cnt      <= '0;
              r_state    <= DATA;
              r_addr_err <= !w_next_ok;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          DATA: begin
            if (w_word_done) begin
              r_cnt <= '0;
              if (w_cur_ok) begin
                r_q[r_addr] <= w_word;
                r_wr_stb    <= 1'b1;
                r_wr_addr   <= r_addr;
                r_full      <= 1'b1;
              end
              if (AUTOINC) begin
                r_addr <= w_addr_inc;
                if (!w_inc_ok) r_addr_err <= 1'b1;
              end else begin
                r_state <= DONE;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: three configurations driven with directed and random frames.
module tb_spi_reg_bank;
`ifdef SPI_REG_BANK_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start [ND];
  logic        sel   [ND];
  logic        si    [ND];
  logic [31:0] din   [ND];
  logic        so_w  [ND];
  logic [31:0] q_w   [ND];
  logic [23:0] q2;
  logic [1:0]  wa    [ND];
  logic        stb   [ND];
  logic        full_w[ND];
  logic        aerr  [ND];

  int          exp_q   [ND][4];
  bit          exp_full[ND];
  bit          exp_err [ND];
  int          chk   = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  spi_reg_bank_if bus0 ();
  spi_reg_bank_if bus1 ();
  spi_reg_bank_if bus2 ();
  assign bus0.start = start[0]; assign bus0.sel = sel[0]; assign bus0.si = si[0];
  assign bus1.start = start[1]; assign bus1.sel = sel[1]; assign bus1.si = si[1];
  assign bus2.start = start[2]; assign bus2.sel = sel[2]; assign bus2.si = si[2];
  assign so_w[0] = bus0.so;
  assign so_w[1] = bus1.so;
  assign so_w[2] = bus2.so;
  assign q_w[2]  = {8'h00, q2};

  spi_reg_bank #(.N(8), .CH(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .data_in(din[0]), .q(q_w[0]),
    .wr_stb(stb[0]), .wr_addr(wa[0]), .full(full_w[0]), .addr_err(aerr[0]));
  spi_reg_bank #(.N(8), .CH(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .data_in(din[1]), .q(q_w[1]),
    .wr_stb(stb[1]), .wr_addr(wa[1]), .full(full_w[1]), .addr_err(aerr[1]));
  spi_reg_bank #(.N(8), .CH(3), .MSB_FIRST(1)) u_ch3 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .data_in(din[2][23:0]), .q(q2),
    .wr_stb(stb[2]), .wr_addr(wa[2]), .full(full_w[2]), .addr_err(aerr[2]));

  function automatic int ch_of(int d);
    return (d == 2) ? 3 : 4;
  endfunction

  function automatic bit msb_of(int d);
    return d != 1;
  endfunction

  task automatic check(string tag, int d, logic [31:0] obs, logic [31:0] expv);
    chk++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(int d);
    for (int c = 0; c < ch_of(d); c++)
      check("q", d, (q_w[d] >> (c*8)) & 32'hFF, 32'(exp_q[d][c]));
    check("full", d, 32'(full_w[d]), 32'(exp_full[d]));
    check("addr_err", d, 32'(aerr[d]), 32'(exp_err[d]));
  endtask

  task automatic maybe_gap(int d, logic exp_so);
    if ($urandom_range(0, 3) == 0) begin
      sel[d] = 1'b0;
      si[d]  = 1'($urandom);
      step();
      check("gap_stb", d, 32'(stb[d]), 32'd0);
      check("gap_so", d, 32'(so_w[d]), 32'(exp_so));
    end
  endtask

  // One session: start, AW address bits, nbits data bits taken from words (low byte first)
  task automatic run_frame(int d, int a, int nbits, logic [15:0] words);
    int       cur, j;
    bit       active, ok;
    bit       m;
    logic [7:0] rb, w;
    logic     eso;
    m = msb_of(d);
    start[d] = 1'b1; sel[d] = 1'($urandom); si[d] = 1'($urandom);
    step();
    exp_full[d] = 1'b0; exp_err[d] = 1'b0;
    check("start_full", d, 32'(full_w[d]), 32'd0);
    check("start_err", d, 32'(aerr[d]), 32'd0);
    start[d] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      maybe_gap(d, 1'b0);
      check("addr_so", d, 32'(so_w[d]), 32'd0);
      sel[d] = 1'b1;
      si[d]  = 1'((a >> (m ? 1 - i : i)) & 1);
      step();
      check("addr_stb", d, 32'(stb[d]), 32'd0);
    end
    cur = a; active = 1'b1; ok = (a < ch_of(d));
    if (!ok) exp_err[d] = 1'b1;
    rb = ok ? din[d][cur*8 +: 8] : 8'h00;
    check("addr_err_latch", d, 32'(aerr[d]), 32'(exp_err[d]));
    for (int b = 0; b < nbits; b++) begin
      j   = b % 8;
      w   = words[(b/8)*8 +: 8];
      eso = active ? rb[m ? 7 - j : j] : 1'b0;
      maybe_gap(d, eso);
      check("so", d, 32'(so_w[d]), 32'(eso));
      sel[d] = 1'b1;
      si[d]  = w[m ? 7 - j : j];
      step();
      if (active && j == 7) begin
        if (ok) begin
          check("wr_stb", d, 32'(stb[d]), 32'd1);
          check("wr_addr", d, 32'(wa[d]), 32'(cur));
          exp_q[d][cur] = int'(w);
          exp_full[d]   = 1'b1;
        end else begin
          check("wr_stb_err", d, 32'(stb[d]), 32'd0);
        end
        if (AUTOINC) begin
          cur = (cur + 1) % 4;
          ok  = (cur < ch_of(d));
          if (!ok) exp_err[d] = 1'b1;
          rb  = ok ? din[d][cur*8 +: 8] : 8'h00;
        end else begin
          active = 1'b0;
        end
      end else begin
        check("no_stb", d, 32'(stb[d]), 32'd0);
      end
    end
    sel[d] = 1'b0;
    step();
    check("stb_end", d, 32'(stb[d]), 32'd0);
    check_regs(d);
  endtask

  task automatic check_all_zero();
    for (int d = 0; d < ND; d++) begin
      check("rst_q", d, q_w[d], 32'd0);
      check("rst_so", d, 32'(so_w[d]), 32'd0);
      check("rst_stb", d, 32'(stb[d]), 32'd0);
      check("rst_waddr", d, 32'(wa[d]), 32'd0);
      check("rst_full", d, 32'(full_w[d]), 32'd0);
      check("rst_err", d, 32'(aerr[d]), 32'd0);
    end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      start[d] = 1'b0; sel[d] = 1'b0; si[d] = 1'b0;
      din[d] = $urandom;
      din[d][23:16] = 8'h3C;
      exp_full[d] = 1'b0; exp_err[d] = 1'b0;
      for (int c = 0; c < 4; c++) exp_q[d][c] = 0;
    end
    #1 reset_n = 1'b0;
    #2 check_all_zero();
    @(posedge clk);
    #3 reset_n = 1'b1;

    // Directed: address 2, data 0xA5, readback 0x3C in each bit order
    run_frame(0, 2, 8, 16'h00A5);
    check("q2_A5_msb", 0, 32'(q_w[0][23:16]), 32'hA5);
    run_frame(1, 2, 8, 16'h00A5);
    check("q2_A5_lsb", 1, 32'(q_w[1][23:16]), 32'hA5);

    // Two-byte frame at address 3: burst wraps to channel 0 only with auto-increment
    run_frame(0, 3, 16, 16'h2211);
    check("q3_11", 0, 32'(q_w[0][31:24]), 32'h11);
    run_frame(1, 3, 16, 16'h2211);

    // Out-of-range address on the 3-channel bank
    run_frame(2, 3, 8, 16'(($urandom)));

    // Abandoned partial word, then a clean frame
    run_frame(0, 1, 5, 16'h00FF);
    run_frame(0, 1, 8, 16'h005A);
    check("q1_5A", 0, 32'(q_w[0][15:8]), 32'h5A);

    for (int it = 0; it < 30; it++) begin
      for (int d = 0; d < ND; d++) begin
        int nb;
        if ($urandom_range(0, 1) == 0) din[d] = $urandom;
        case ($urandom_range(0, 2))
          0:       nb = 8;
          1:       nb = 16;
          default: nb = $urandom_range(1, 16);
        endcase
        run_frame(d, $urandom_range(0, 3), nb, 16'($urandom));
      end
    end

    // Asynchronous reset while mid-word in the data phase
    for (int d = 0; d < ND; d++) begin
      run_frame(d, 1, 8, 16'h00C3);
      run_frame(d, 2, 3, 16'h0000);
    end
    #2 reset_n = 1'b0;
    #1 check_all_zero();
    for (int d = 0; d < ND; d++) begin
      exp_full[d] = 1'b0; exp_err[d] = 1'b0;
      for (int c = 0; c < 4; c++) exp_q[d][c] = 0;
    end
    #1 reset_n = 1'b1;
    run_frame(1, 0, 8, 16'h0096);

    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $finish;
  end
endmodule
